soc_reset_seq: RTL



---
 rtl/soc_reset_seq.sv | 92 +++++++++
 1 files changed

// File: rtl/soc_reset_seq.sv
// Reset sequencer: stretched, ordered soc_rst/core_rst from PLL lock and request strobes.
// Outputs registered (change on the edge the state changes); no backpressure, requests always accepted.
module soc_reset_seq #(
  parameter int SOC_HOLD   = 16,
  parameter int CORE_DELAY = 8,
  parameter int CORE_HOLD  = 16,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  input  logic soc_reset_req,
  input  logic core_reset_req,
  output logic soc_rst,
  output logic core_rst,
  output logic seq_busy
);

  typedef enum logic [1:0] {
    HOLD_SOC  = 2'd0,
    HOLD_CORE = 2'd1,
    CORE_ONLY = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] SOC_LAST   = CNT_W'(SOC_HOLD - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(CORE_DELAY - 1);
  localparam logic [CNT_W-1:0] CORE_LAST  = CNT_W'(CORE_HOLD - 1);

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 1'b1;
    // Lock loss and SoC requests restart the full sequence from any state.
    if (!pll_locked || soc_reset_req) begin
      nxt_state = HOLD_SOC;
      nxt_cnt   = '0;
    end else begin
      unique case (state)
        HOLD_SOC: begin
          if (cnt == SOC_LAST) begin
            nxt_state = HOLD_CORE;
            nxt_cnt   = '0;
          end
        end
        HOLD_CORE: begin
          if (cnt == DELAY_LAST) begin
            nxt_state = RUN;
            nxt_cnt   = '0;
          end
        end
        CORE_ONLY: begin
          if (core_reset_req) begin
            nxt_cnt = '0;
          end else if (cnt == CORE_LAST) begin
            nxt_state = RUN;
            nxt_cnt   = '0;
          end
        end
        RUN: begin
          nxt_cnt = '0;
          if (core_reset_req) begin
            nxt_state = CORE_ONLY;
          end
        end
        default: begin
          nxt_state = HOLD_SOC;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= HOLD_SOC;
      cnt      <= '0;
      soc_rst  <= 1'b1;
      core_rst <= 1'b1;
      seq_busy <= 1'b1;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      soc_rst  <= (nxt_state == HOLD_SOC);
      core_rst <= (nxt_state != RUN);
      seq_busy <= (nxt_state != RUN);
    end
  end

endmodule
